// File: rtl/fir_sched_if.sv
// fir_sched_if: AXI-Stream input and output channels of the FIR sequencer.
// slave is the sequencer's view; master is the view of whatever surrounds it.
interface fir_sched_if #(
  parameter int pDATA_WIDTH = 32
);
  logic                   ss_tvalid;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   ss_tlast;
  logic                   ss_tready;

  logic                   sm_tvalid;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   sm_tlast;
  logic                   sm_tready;

  modport slave (
    input  ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    output ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );

  modport master (
    output ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    input  ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );
endinterface

// File: rtl/fir_sched.sv
// fir_sched: run sequencer for the FIR datapath. One run per ap_start: clear
// the circular sample buffer, then for each accepted sample do an N-tap
// multiply-accumulate and emit the result on the output stream.
// Optional macro FIR_TLAST_STOP_EN: an input sample carrying ss_tlast=1 makes
// its output the final one of the run.
module fir_sched #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int RAM_ADDR    = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_start,
  input  logic [pDATA_WIDTH-1:0] data_length,
  output logic                   ap_done,
  output logic                   ap_idle,
  fir_sched_if.slave             strm,
  output logic [RAM_ADDR-1:0]    FIR_raddr,
  input  logic [pDATA_WIDTH-1:0] FIR_rdata,
  output logic                   data_EN,
  output logic [3:0]             data_WE,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  input  logic [pDATA_WIDTH-1:0] data_Do
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_ACC, S_OUT, S_DONE
  } state_t;

  localparam logic [RAM_ADDR-1:0]    LAST_TAP = RAM_ADDR'(Tape_Num - 1);
  localparam logic [RAM_ADDR-1:0]    TAP_ONE  = RAM_ADDR'(1);
  localparam logic [RAM_ADDR-1:0]    TAP_NUM  = RAM_ADDR'(Tape_Num);
  localparam logic [pDATA_WIDTH-1:0] CNT_ONE  = pDATA_WIDTH'(1);

  state_t                        state, state_nx;
  logic [RAM_ADDR-1:0]           wp;       // buffer slot of the newest sample
  logic [RAM_ADDR-1:0]           tap;      // tap / clear index
  logic [RAM_ADDR-1:0]           tap_idx;  // (wp - tap) mod N
  logic [pDATA_WIDTH-1:0]        cnt;      // outputs delivered this run
  logic [pDATA_WIDTH-1:0]        len_q;    // data_length latched at start
  logic signed [pDATA_WIDTH-1:0] acc;
  logic                          ss_hs, sm_hs, is_last;

  // Wrap-around accumulate of the low word of a signed product.
  function automatic logic signed [pDATA_WIDTH-1:0] mac_wrap(
    input logic signed [pDATA_WIDTH-1:0] a,
    input logic signed [pDATA_WIDTH-1:0] h,
    input logic signed [pDATA_WIDTH-1:0] x
  );
    logic signed [2*pDATA_WIDTH-1:0] prod;
    prod = h * x;
    return a + $signed(prod[pDATA_WIDTH-1:0]);
  endfunction

  // Sample-RAM byte address of a buffer slot.
  function automatic logic [pADDR_WIDTH-1:0] ram_addr(input logic [RAM_ADDR-1:0] idx);
    return pADDR_WIDTH'({idx, 2'b00});
  endfunction

  assign ss_hs = (state == S_WAIT_IN) && strm.ss_tvalid;
  assign sm_hs = (state == S_OUT) && strm.sm_tready;

`ifdef FIR_TLAST_STOP_EN
  logic tlast_q;

  // Remember whether the sample in flight closed the input stream.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) tlast_q <= 1'b0;
    else if (ss_hs) tlast_q <= strm.ss_tlast;
  end

  assign is_last = (cnt == len_q - CNT_ONE) || tlast_q;
`else
  assign is_last = (cnt == len_q - CNT_ONE);
`endif

  // Circular read slot: modular subtraction in RAM_ADDR bits stays exact
  // because the final result is always below N.
  always_comb begin
    if (wp >= tap) tap_idx = wp - tap;
    else           tap_idx = wp + TAP_NUM - tap;
  end

  // State register.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state decision.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (ap_start) state_nx = (data_length == '0) ? S_DONE : S_CLEAR;
      S_CLEAR:   if (tap == LAST_TAP) state_nx = S_WAIT_IN;
      S_WAIT_IN: if (strm.ss_tvalid) state_nx = S_MAC;
      S_MAC:     if (tap == LAST_TAP) state_nx = S_ACC;
      S_ACC:     state_nx = S_OUT;
      S_OUT:     if (strm.sm_tready) state_nx = is_last ? S_DONE : S_WAIT_IN;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Counters, write pointer, run length and accumulator.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      wp    <= '0;
      tap   <= '0;
      cnt   <= '0;
      len_q <= '0;
      acc   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ap_start) len_q <= data_length;
          tap <= '0;
        end
        S_CLEAR: begin
          tap <= (tap == LAST_TAP) ? '0 : tap + TAP_ONE;
          wp  <= '0;
          cnt <= '0;
        end
        S_WAIT_IN: begin
          if (ss_hs) begin
            acc <= '0;
            tap <= '0;
          end
        end
        S_MAC: begin
          // Coefficient and sample for tap-1 arrive one cycle after their address.
          if (tap != '0) acc <= mac_wrap(acc, $signed(FIR_rdata), $signed(data_Do));
          tap <= (tap == LAST_TAP) ? '0 : tap + TAP_ONE;
        end
        S_ACC: acc <= mac_wrap(acc, $signed(FIR_rdata), $signed(data_Do));
        S_OUT: begin
          if (sm_hs) begin
            wp  <= (wp == LAST_TAP) ? '0 : wp + TAP_ONE;
            cnt <= cnt + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state: RAM port, coefficient address, streams, status.
  always_comb begin
    ap_done        = 1'b0;
    ap_idle        = 1'b0;
    strm.ss_tready = 1'b0;
    strm.sm_tvalid = 1'b0;
    strm.sm_tdata  = '0;
    strm.sm_tlast  = 1'b0;
    FIR_raddr      = '0;
    data_EN        = 1'b0;
    data_WE        = 4'h0;
    data_A         = '0;
    data_Di        = '0;
    unique case (state)
      S_IDLE: ap_idle = 1'b1;
      S_CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = ram_addr(tap);
      end
      S_WAIT_IN: begin
        strm.ss_tready = 1'b1;
        if (strm.ss_tvalid) begin
          data_EN = 1'b1;
          data_WE = 4'hF;
          data_A  = ram_addr(wp);
          data_Di = strm.ss_tdata;
        end
      end
      S_MAC: begin
        FIR_raddr = tap;
        data_EN   = 1'b1;
        data_A    = ram_addr(tap_idx);
      end
      S_ACC: ;
      S_OUT: begin
        strm.sm_tvalid = 1'b1;
        strm.sm_tdata  = acc;
        strm.sm_tlast  = is_last;
      end
      S_DONE: ap_done = 1'b1;
      default: ;
    endcase
  end

endmodule
